mux4x1_arbiter: RTL and testbench

MUX4X1_ARBITER -- requirements
Module: mux4x1_arbiter

---
 rtl/mux4x1_arbiter_pkg.sv | 12 +
 rtl/mux4x1_arbiter_rr_pick4.sv | 27 ++
 rtl/mux4x1_arbiter.sv | 124 ++++++++++++
 tb/tb_mux4x1_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4x1_arbiter_pkg.sv
// Shared constants and types for the team's small mux/arbiter blocks.
package mux4x1_arbiter_pkg;

    localparam int NUM_REQ          = 4;
    localparam int MAX_HOLD_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux4x1_arbiter_rr_pick4.sv
// Rotating-priority search over four requesters, starting at i_ptr.
module rr_pick4
    import mux4x1_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic [1:0]         o_winner,
    output logic               o_found
);

    logic [1:0] w_idx;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_winner = i_ptr;
        o_found  = 1'b0;
        w_idx    = i_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4x1_arbiter.sv
// Round-robin 4:1 arbiter with a bounded hold time and a registered data select.
//   state    | meaning
//   ST_IDLE  | no requester granted; gnt=0, out_valid=0
//   ST_GRANT | requester sel owns the output; r_cnt counts consecutive cycles
module mux4x1_arbiter
    import mux4x1_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_d,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [1:0]         o_sel,
    output logic               o_out_valid,
    output logic               o_out
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    arb_state_t          r_state;
    logic [1:0]          r_ptr;
    logic [3:0]          r_cnt;
    logic [1:0]          r_sel;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_valid;

    arb_state_t          w_nxt_state;
    logic [1:0]          w_nxt_ptr;
    logic [3:0]          w_nxt_cnt;
    logic [1:0]          w_nxt_sel;
    logic [NUM_REQ-1:0]  w_nxt_gnt;
    logic                w_nxt_valid;

    logic                w_release;
    logic [1:0]          w_pick_ptr;
    logic [1:0]          w_winner;
    logic                w_found;
    logic [NUM_REQ-1:0]  w_winner_oh;

    // On release the search already starts one past the current owner,
    // which puts the releasing requester at lowest priority.
    assign w_release   = (r_state == ST_GRANT) && (!i_req[r_sel] || (r_cnt == HOLD_LIMIT));
    assign w_pick_ptr  = (r_state == ST_GRANT) ? (r_sel + 2'd1) : r_ptr;
    assign w_winner_oh = 4'b0001 << w_winner;

    rr_pick4 u_pick (
        .i_req    (i_req),
        .i_ptr    (w_pick_ptr),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_cnt   = r_cnt;
        w_nxt_sel   = r_sel;
        w_nxt_gnt   = r_gnt;
        w_nxt_valid = r_valid;
        case (r_state)
            ST_IDLE: begin
                w_nxt_gnt   = '0;
                w_nxt_valid = 1'b0;
                if (w_found) begin
                    w_nxt_state = ST_GRANT;
                    w_nxt_sel   = w_winner;
                    w_nxt_gnt   = w_winner_oh;
                    w_nxt_valid = 1'b1;
                    w_nxt_cnt   = 4'd1;
                end
            end
            ST_GRANT: begin
                if (!w_release) begin
                    w_nxt_cnt = r_cnt + 4'd1;
                end else begin
                    w_nxt_ptr = w_pick_ptr;
                    if (w_found) begin
                        w_nxt_sel   = w_winner;
                        w_nxt_gnt   = w_winner_oh;
                        w_nxt_valid = 1'b1;
                        w_nxt_cnt   = 4'd1;
                    end else begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_gnt   = '0;
                        w_nxt_valid = 1'b0;
                        w_nxt_cnt   = 4'd0;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_gnt   = '0;
                w_nxt_valid = 1'b0;
                w_nxt_cnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= 4'd0;
            r_sel   <= 2'd0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_cnt   <= w_nxt_cnt;
            r_sel   <= w_nxt_sel;
            r_gnt   <= w_nxt_gnt;
            r_valid <= w_nxt_valid;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_sel       = r_sel;
    assign o_out_valid = r_valid;
    assign o_out       = r_valid ? i_d[r_sel] : 1'b0;

endmodule

// File: tb/tb_mux4x1_arbiter.sv
// Scenario bench for mux4x1_arbiter: expected outputs queued at drive time, compared after each edge.
module tb_mux4x1_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [3:0] i_req;
    logic [3:0] i_d;
    logic [3:0] o_gnt;
    logic [1:0] o_sel;
    logic       o_out_valid;
    logic       o_out;

    int checks   = 0;
    int failures = 0;
    logic inv_en = 1'b0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       sel_care;
        logic       valid;
        logic       out;
    } exp_t;

    exp_t sb_q[$];

    always #5 i_clk = ~i_clk;

    mux4x1_arbiter #(.MAX_HOLD(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_d         (i_d),
        .o_gnt       (o_gnt),
        .o_sel       (o_sel),
        .o_out_valid (o_out_valid),
        .o_out       (o_out)
    );

    // One-hot and valid/grant agreement, sampled on the inactive edge.
    always @(negedge i_clk) begin
        if (inv_en) begin
            checks++;
            if ($countones(o_gnt) > 1 || ((o_gnt != 4'b0000) !== o_out_valid)) begin
                failures++;
                $display("FAIL invariant gnt=%b out_valid=%b (need at most one bit, valid iff gnt!=0)",
                         o_gnt, o_out_valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] onehot(input logic [1:0] s);
        logic [3:0] base;
        base = 4'b0001;
        return base << s;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [3:0] gnt, input logic [1:0] sel, input logic sel_care,
                        input logic out);
        exp_t e;
        e.gnt      = gnt;
        e.sel      = sel;
        e.sel_care = sel_care;
        e.valid    = (gnt != 4'b0000);
        e.out      = out;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_req = 4'b0000;
        i_d   = 4'b0000;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        i_rst = 1'b1;
        i_req = 4'b1111;
        i_d   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) i_rst = 1'b0;
            if (i < 2) push(4'b0000, 2'd0, 1'b1, 1'b0);
            else       push(4'b0001, 2'd0, 1'b1, 1'b1);
            tick();
            e = sb_q.pop_front();
            checks++;
            if (o_gnt !== e.gnt || o_out_valid !== e.valid || o_out !== e.out ||
                (e.sel_care && o_sel !== e.sel)) begin
                failures++;
                $display("FAIL reset[%0d] got gnt=%b sel=%0d valid=%b out=%b want gnt=%b sel=%0d valid=%b out=%b",
                         i, o_gnt, o_sel, o_out_valid, o_out, e.gnt, e.sel, e.valid, e.out);
            end
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        logic [3:0] dpat;
        logic [1:0] s;
        do_reset();
        dpat  = 4'b1010;
        i_d   = dpat;
        i_req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            s = 2'((i / 4) % 4);
            push(onehot(s), s, 1'b1, dpat[s]);
            tick();
            e = sb_q.pop_front();
            checks++;
            if (o_gnt !== e.gnt || o_out_valid !== e.valid || o_out !== e.out ||
                (e.sel_care && o_sel !== e.sel)) begin
                failures++;
                $display("FAIL rotation[%0d] got gnt=%b sel=%0d valid=%b out=%b want gnt=%b sel=%0d valid=%b out=%b",
                         i, o_gnt, o_sel, o_out_valid, o_out, e.gnt, e.sel, e.valid, e.out);
            end
        end
    endtask

    task automatic test_idle_return();
        exp_t e;
        logic [3:0] reqs [6] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0101, 4'b0101};
        do_reset();
        i_d = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            i_req = reqs[i];
            if (i < 2)      push(4'b0100, 2'd2, 1'b1, 1'b0);
            else if (i < 4) push(4'b0000, 2'd0, 1'b0, 1'b0);
            else            push(4'b0001, 2'd0, 1'b1, 1'b1);
            tick();
            e = sb_q.pop_front();
            checks++;
            if (o_gnt !== e.gnt || o_out_valid !== e.valid || o_out !== e.out ||
                (e.sel_care && o_sel !== e.sel)) begin
                failures++;
                $display("FAIL idle_return[%0d] got gnt=%b sel=%0d valid=%b out=%b want gnt=%b sel=%0d valid=%b out=%b",
                         i, o_gnt, o_sel, o_out_valid, o_out, e.gnt, e.sel, e.valid, e.out);
            end
        end
    endtask

    task automatic test_single_hold();
        exp_t e;
        do_reset();
        i_d   = 4'b0010;
        i_req = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            push(4'b0010, 2'd1, 1'b1, 1'b1);
            tick();
            e = sb_q.pop_front();
            checks++;
            if (o_gnt !== e.gnt || o_out_valid !== e.valid || o_out !== e.out ||
                (e.sel_care && o_sel !== e.sel)) begin
                failures++;
                $display("FAIL single_hold[%0d] got gnt=%b sel=%0d valid=%b out=%b want gnt=%b sel=%0d valid=%b out=%b",
                         i, o_gnt, o_sel, o_out_valid, o_out, e.gnt, e.sel, e.valid, e.out);
            end
        end
        i_d = 4'b1101;
        #1;
        checks++;
        if (o_out !== 1'b0) begin
            failures++;
            $display("FAIL out_comb got out=%b want 0 after d[1] cleared", o_out);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] reqs [6] = '{4'b1000, 4'b0011, 4'b0111, 4'b0011, 4'b0011, 4'b0111};
        logic [1:0] sels [6] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        logic [3:0] dpat;
        do_reset();
        dpat = 4'b1001;
        i_d  = dpat;
        for (int i = 0; i < 6; i++) begin
            i_req = reqs[i];
            push(onehot(sels[i]), sels[i], 1'b1, dpat[sels[i]]);
            tick();
            e = sb_q.pop_front();
            checks++;
            if (o_gnt !== e.gnt || o_out_valid !== e.valid || o_out !== e.out ||
                (e.sel_care && o_sel !== e.sel)) begin
                failures++;
                $display("FAIL back_to_back[%0d] got gnt=%b sel=%0d valid=%b out=%b want gnt=%b sel=%0d valid=%b out=%b",
                         i, o_gnt, o_sel, o_out_valid, o_out, e.gnt, e.sel, e.valid, e.out);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        exp_t e;
        logic [1:0] s;
        do_reset();
        i_d   = 4'b0010;
        i_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            i_rst = (i == 6);
            if (i == 6) begin
                push(4'b0000, 2'd0, 1'b1, 1'b0);
            end else begin
                s = (i < 4 || i == 7) ? 2'd0 : 2'd1;
                push(onehot(s), s, 1'b1, s == 2'd1);
            end
            tick();
            e = sb_q.pop_front();
            checks++;
            if (o_gnt !== e.gnt || o_out_valid !== e.valid || o_out !== e.out ||
                (e.sel_care && o_sel !== e.sel)) begin
                failures++;
                $display("FAIL reset_mid_grant[%0d] got gnt=%b sel=%0d valid=%b out=%b want gnt=%b sel=%0d valid=%b out=%b",
                         i, o_gnt, o_sel, o_out_valid, o_out, e.gnt, e.sel, e.valid, e.out);
            end
        end
        i_rst = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_req = 4'b0000;
        i_d   = 4'b0000;
        @(posedge i_clk);
        #1;
        inv_en = 1'b1;
        test_reset();
        test_rotation();
        test_idle_return();
        test_single_hold();
        test_back_to_back();
        test_reset_mid_grant();
        inv_en = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
